// File: rtl/scd_pkg.sv
// -----------------------------------------------------------------------------
// scd_pkg
// Shared constants and helpers for the scan_counter_display slice.
//   - MODE_HEX / MODE_DEC : values of the counter radix select input
//   - SEG_0 .. SEG_F      : active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK           : all segments off
//   - hex_to_sseg()       : nibble to active-low glyph
// -----------------------------------------------------------------------------
package scd_pkg;

   localparam logic MODE_HEX = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] hex_to_sseg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         4'hF:    seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/scd_digit.sv
// -----------------------------------------------------------------------------
// scd_digit
// One 4-bit up/down counter digit with hex or decimal modulus.
// Ports:
//   clk, reset  : board clock, asynchronous active-high reset
//   step_en     : advance this digit this cycle (carry/borrow from below)
//   updown      : 1 = up, 0 = down
//   mode        : MODE_DEC (modulus 10) or MODE_HEX (modulus 16)
//   load        : synchronous load strobe, wins over step_en
//   load_value  : value taken verbatim on load
//   value       : current digit register
//   terminal    : digit sits at its roll-over value for the current direction
// -----------------------------------------------------------------------------
module scd_digit
   import scd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       step_en,
   input  logic       updown,
   input  logic       mode,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic [3:0] value,
   output logic       terminal
);

   logic [3:0] value_r;
   logic [3:0] max_s;
   logic [3:0] next_s;
   logic       terminal_s;

   // Terminal detection and next value; a decimal digit above 9 counts as
   // terminal going up and snaps to 9 going down.
   always_comb begin
      max_s      = (mode == MODE_DEC) ? 4'd9 : 4'd15;
      terminal_s = 1'b0;
      next_s     = value_r;
      if (updown) begin
         terminal_s = (value_r >= max_s);
         next_s     = terminal_s ? 4'd0 : (value_r + 4'd1);
      end else begin
         terminal_s = (value_r == 4'd0);
         if (terminal_s) begin
            next_s = max_s;
         end else if (value_r > max_s) begin
            next_s = max_s;
         end else begin
            next_s = value_r - 4'd1;
         end
      end
   end

   // Digit register: load has priority over a step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_r <= 4'd0;
      end else if (load) begin
         value_r <= load_value;
      end else if (step_en) begin
         value_r <= next_s;
      end else begin
         value_r <= value_r;
      end
   end

   assign value    = value_r;
   assign terminal = terminal_s;

endmodule

// File: rtl/scan_counter_display.sv
// -----------------------------------------------------------------------------
// scan_counter_display
// Multi-digit up/down counter with a seven-segment scan driver, all on clk
// using tick enables.
// Parameters: NUM_DIGITS (1..8), CLK_HZ (base step period), SCAN_DIV_W
//   (scan tick every 2^SCAN_DIV_W clocks).
// Ports:
//   clk, reset  : board clock, asynchronous active-high reset
//   enable      : allow counting on step ticks
//   updown      : 1 = up, 0 = down
//   mode        : 1 = decimal, 0 = hex
//   speed       : step period = max(1, CLK_HZ >> speed) cycles
//   load        : synchronous load of load_value (no wrap pulse)
//   load_value  : digit 0 in bits [3:0]
//   count       : current count
//   wrap        : one-cycle pulse on full-chain roll-over
//   sseg        : active-low segments {g,f,e,d,c,b,a}
//   an          : active-low one-hot anode of the scanned digit
// Optional macro LEADING_ZERO_BLANK_EN: blank digits above the most
//   significant nonzero digit (digit 0 always shown).
// -----------------------------------------------------------------------------
module scan_counter_display
   import scd_pkg::*;
#(
   parameter int          NUM_DIGITS = 4,
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int          SCAN_DIV_W = 17
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    updown,
   input  logic                    mode,
   input  logic [4:0]              speed,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    wrap,
   output logic [6:0]              sseg,
   output logic [7:0]              an
);

   logic [31:0]           step_cnt_r;
   logic [31:0]           period_s;
   logic                  step_tick_s;
   logic [NUM_DIGITS:0]   chain_s;
   logic [NUM_DIGITS-1:0] term_s;
   logic [3:0]            digit_val_s [NUM_DIGITS];
   logic                  wrap_r;
   logic [SCAN_DIV_W-1:0] scan_div_r;
   logic                  scan_tick_s;
   logic [2:0]            scan_idx_r;
   logic [3:0]            digit_s;
   logic [2:0]            msd_s;
   logic [6:0]            sseg_s;
   logic [7:0]            an_s;

   // Step period; ">=" lets a speed change that shortens the period fire at once.
   always_comb begin
      period_s = 32'(CLK_HZ) >> speed;
      if (period_s == 32'd0) begin
         period_s = 32'd1;
      end else begin
         period_s = period_s;
      end
      step_tick_s = (step_cnt_r >= (period_s - 32'd1));
   end

   // Free-running step counter, independent of enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_cnt_r <= 32'd0;
      end else if (step_tick_s) begin
         step_cnt_r <= 32'd0;
      end else begin
         step_cnt_r <= step_cnt_r + 32'd1;
      end
   end

   // A load blocks the chain so it never produces a wrap.
   assign chain_s[0] = step_tick_s & enable & ~load;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      scd_digit u_digit (
         .clk        (clk),
         .reset      (reset),
         .step_en    (chain_s[g]),
         .updown     (updown),
         .mode       (mode),
         .load       (load),
         .load_value (load_value[4*g +: 4]),
         .value      (digit_val_s[g]),
         .terminal   (term_s[g])
      );
      assign chain_s[g+1]       = chain_s[g] & term_s[g];
      assign count[4*g +: 4]    = digit_val_s[g];
   end

   // Wrap pulse: every digit rolled over in this step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_r <= 1'b0;
      end else begin
         wrap_r <= chain_s[NUM_DIGITS];
      end
   end

   assign scan_tick_s = &scan_div_r;

   // Scan divider and digit index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_div_r <= '0;
         scan_idx_r <= 3'd0;
      end else begin
         scan_div_r <= scan_div_r + SCAN_DIV_W'(1);
         if (scan_tick_s) begin
            if (scan_idx_r == 3'(NUM_DIGITS - 1)) begin
               scan_idx_r <= 3'd0;
            end else begin
               scan_idx_r <= scan_idx_r + 3'd1;
            end
         end else begin
            scan_idx_r <= scan_idx_r;
         end
      end
   end

   // Selected digit and most significant nonzero digit position.
   always_comb begin
      digit_s = 4'd0;
      msd_s   = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx_r == 3'(i)) begin
            digit_s = digit_val_s[i];
         end else begin
            digit_s = digit_s;
         end
         if (digit_val_s[i] != 4'd0) begin
            msd_s = 3'(i);
         end else begin
            msd_s = msd_s;
         end
      end
   end

   // Anode and segment drive, combinational from scan_idx and count.
   always_comb begin
      an_s   = 8'hFF;
      sseg_s = hex_to_sseg(digit_s);
`ifdef LEADING_ZERO_BLANK_EN
      if (scan_idx_r > msd_s) begin
         sseg_s = SEG_BLANK;
      end else begin
         an_s[scan_idx_r] = 1'b0;
      end
`else
      an_s[scan_idx_r] = 1'b0;
`endif
   end

   assign wrap = wrap_r;
   assign sseg = sseg_s;
   assign an   = an_s;

endmodule

// File: tb/tb_scan_counter_display.sv
// -----------------------------------------------------------------------------
// tb_scan_counter_display
// Directed self-checking bench for scan_counter_display (NUM_DIGITS=4,
// SCAN_DIV_W=2, default CLK_HZ). Honors LEADING_ZERO_BLANK_EN when defined.
// -----------------------------------------------------------------------------
module tb_scan_counter_display;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        updown;
   logic        mode;
   logic [4:0]  speed;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] count;
   logic        wrap;
   logic [6:0]  sseg;
   logic [7:0]  an;

   int vectors;
   int miscompares;

   scan_counter_display #(
      .NUM_DIGITS (4),
      .CLK_HZ     (100000000),
      .SCAN_DIV_W (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .updown     (updown),
      .mode       (mode),
      .speed      (speed),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .wrap       (wrap),
      .sseg       (sseg),
      .an         (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; updown = 1'b1; mode = 1'b1;
      speed = 5'd26; load = 1'b0; load_value = 16'h0000;
      #12;
      vectors++;
      if (count !== 16'h0000) begin miscompares++; $display("FAIL reset_count got %h want %h", count, 16'h0000); end
      vectors++;
      if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap got %b want 0", wrap); end
      vectors++;
      if (an !== 8'hFE) begin miscompares++; $display("FAIL reset_an got %h want FE", an); end
      vectors++;
      if (sseg !== 7'b1000000) begin miscompares++; $display("FAIL reset_sseg got %b want 1000000", sseg); end
      tick();
   endtask

   task automatic test_count();
      logic [15:0] exp;
      reset = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp = (k == 10) ? 16'h0010 : 16'(k);
         vectors++;
         if (count !== exp) begin miscompares++; $display("FAIL count_step%0d got %h want %h", k, count, exp); end
      end
      enable = 1'b0;
   endtask

   task automatic test_dec_wrap();
      mode = 1'b1; updown = 1'b1; load = 1'b1; load_value = 16'h9999;
      tick();
      vectors++;
      if (count !== 16'h9999 || wrap !== 1'b0) begin miscompares++; $display("FAIL dec_load got %h/%b want 9999/0", count, wrap); end
      load = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      vectors++;
      if (count !== 16'h0000 || wrap !== 1'b1) begin miscompares++; $display("FAIL dec_wrap got %h/%b want 0000/1", count, wrap); end
      tick();
      vectors++;
      if (count !== 16'h0000 || wrap !== 1'b0) begin miscompares++; $display("FAIL dec_wrap_end got %h/%b want 0000/0", count, wrap); end
   endtask

   task automatic test_hex_down_hold();
      mode = 1'b0; updown = 1'b0; load = 1'b1; load_value = 16'h0000;
      tick();
      load = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      vectors++;
      if (count !== 16'hFFFF || wrap !== 1'b1) begin miscompares++; $display("FAIL hex_down got %h/%b want FFFF/1", count, wrap); end
      repeat (10) tick();
      vectors++;
      if (count !== 16'hFFFF || wrap !== 1'b0) begin miscompares++; $display("FAIL hold got %h/%b want FFFF/0", count, wrap); end
   endtask

   task automatic test_load_priority();
      mode = 1'b1; updown = 1'b1; enable = 1'b1; load = 1'b1; load_value = 16'h1234;
      tick();
      vectors++;
      if (count !== 16'h1234 || wrap !== 1'b0) begin miscompares++; $display("FAIL load_prio got %h/%b want 1234/0", count, wrap); end
      load = 1'b0;
      tick();
      enable = 1'b0;
      vectors++;
      if (count !== 16'h1235) begin miscompares++; $display("FAIL after_load got %h want 1235", count); end
   endtask

   task automatic test_mode_switch();
      mode = 1'b0; load = 1'b1; load_value = 16'h000C;
      tick();
      load = 1'b0; mode = 1'b1; updown = 1'b1; enable = 1'b1;
      tick();
      enable = 1'b0;
      vectors++;
      if (count !== 16'h0010) begin miscompares++; $display("FAIL dec_up_from_C got %h want 0010", count); end
      load = 1'b1; load_value = 16'h000C;
      tick();
      load = 1'b0; updown = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      vectors++;
      if (count !== 16'h0009) begin miscompares++; $display("FAIL dec_down_from_C got %h want 0009", count); end
      load = 1'b1; load_value = 16'h0010;
      tick();
      load = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      vectors++;
      if (count !== 16'h0009) begin miscompares++; $display("FAIL dec_borrow got %h want 0009", count); end
   endtask

   task automatic test_step_period();
      logic [15:0] exp;
      reset = 1'b1;
      #1;
      vectors++;
      if (count !== 16'h0000) begin miscompares++; $display("FAIL async_reset got %h want 0000", count); end
      speed = 5'd24; enable = 1'b1; updown = 1'b1; mode = 1'b0; load = 1'b0;
      tick();
      reset = 1'b0;
      // 100e6 >> 24 = 5 cycles per step
      for (int c = 1; c <= 10; c++) begin
         tick();
         exp = 16'(c / 5);
         vectors++;
         if (count !== exp) begin miscompares++; $display("FAIL period_cyc%0d got %h want %h", c, count, exp); end
      end
      enable = 1'b0; speed = 5'd26;
   endtask

   task automatic test_scan();
      int          idx;
      logic [15:0] val;
      logic [3:0]  d;
      logic [7:0]  exp_an;
      val = 16'hA5C3;
      reset = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b1; load_value = val;
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         load = 1'b0;
         idx    = (c / 4) % 4;
         d      = 4'((val >> (4 * idx)) & 16'h000F);
         exp_an = ~(8'h01 << idx);
         vectors++;
         if (an !== exp_an) begin miscompares++; $display("FAIL scan_an_cyc%0d got %h want %h", c, an, exp_an); end
         vectors++;
         if (sseg !== exp_glyph(d)) begin miscompares++; $display("FAIL scan_sseg_cyc%0d got %b want %b", c, sseg, exp_glyph(d)); end
      end
   endtask

   task automatic test_blank();
      int         idx;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      reset = 1'b1; enable = 1'b0; load = 1'b1; load_value = 16'h0005;
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         load = 1'b0;
         idx = (c / 4) % 4;
         if (idx == 0) begin
            exp_an  = 8'hFE;
            exp_seg = exp_glyph(4'h5);
         end else begin
`ifdef LEADING_ZERO_BLANK_EN
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
`else
            exp_an  = ~(8'h01 << idx);
            exp_seg = exp_glyph(4'h0);
`endif
         end
         vectors++;
         if (an !== exp_an) begin miscompares++; $display("FAIL blank_an_cyc%0d got %h want %h", c, an, exp_an); end
         vectors++;
         if (sseg !== exp_seg) begin miscompares++; $display("FAIL blank_sseg_cyc%0d got %b want %b", c, sseg, exp_seg); end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_count();
      test_dec_wrap();
      test_hex_down_hold();
      test_load_priority();
      test_mode_switch();
      test_step_period();
      test_scan();
      test_blank();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
